mvm_engine: RTL and testbench

Sequential matrix-vector multiply block for the neural-network accelerator datapath. It multiplies a MATRIX_ROWS x SHARED_DIM matrix of unsigned WIDTH-bit weights by a binary (1-bit-per-element) activation vector. It produces one accumulated result per matrix row, computing one row per clock cycle under a single-pulse start command.

---
 rtl/mvm_engine.sv | 104 ++++++++++
 tb/tb_mvm_engine.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mvm_engine.sv
// Sequential matrix x binary-vector multiply: one row's masked sum per clock,
// launched by a single start pulse and held until the next accepted start.
module mvm_engine #(
    parameter int MATRIX_ROWS = 6,
    parameter int SHARED_DIM  = 3,
    parameter int WIDTH       = 8
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      start,
    input  logic [MATRIX_ROWS*SHARED_DIM*WIDTH-1:0]   matrix,
    input  logic [MATRIX_ROWS-1:0]                    vector,
    output logic [MATRIX_ROWS*SHARED_DIM*WIDTH-1:0]   result_vector
);

    // A row of the matrix and a result field share the same width.
    localparam int ROW_BITS = SHARED_DIM * WIDTH;
    localparam int ROW_W    = (MATRIX_ROWS > 1) ? $clog2(MATRIX_ROWS) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MATRIX_ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_DONE
    } state_t;

    state_t                            r_state;
    state_t                            w_next_state;
    logic [ROW_W-1:0]                  r_row;
    logic [MATRIX_ROWS*ROW_BITS-1:0]   r_matrix;
    logic [SHARED_DIM-1:0]             r_vector;
    logic [MATRIX_ROWS*ROW_BITS-1:0]   r_result;
    logic [ROW_BITS-1:0]               w_row_elems;
    logic [ROW_BITS-1:0]               w_row_sum;
    logic                              w_accept;
    logic                              w_last_row;

    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_last_row = (r_row == LAST_ROW);

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the default assignment first means no path leaves w_next_state
    // unassigned, so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next_state = S_COMPUTE;
            S_COMPUTE: if (w_last_row) w_next_state = S_DONE;
            S_DONE:    w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    assign w_row_elems = r_matrix[r_row*ROW_BITS +: ROW_BITS];

    // Binary activations turn the dot product into a masked sum; no multipliers.
    always_comb begin
        w_row_sum = '0;
        for (int c = 0; c < SHARED_DIM; c++) begin
            if (r_vector[c]) begin
                w_row_sum = w_row_sum + ROW_BITS'(w_row_elems[c*WIDTH +: WIDTH]);
            end
        end
    end

    // NOTE: the operand and result registers are small and must read 0 after
    // reset, so they are reset like any other flop rather than left as memory.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row    <= '0;
            r_matrix <= '0;
            r_vector <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_row    <= '0;
            r_matrix <= matrix;
            r_vector <= vector[SHARED_DIM-1:0];
            r_result <= '0;
        end else if (r_state == S_COMPUTE) begin
            r_result[r_row*ROW_BITS +: ROW_BITS] <= w_row_sum;
            r_row <= w_last_row ? '0 : r_row + 1'b1;
        end
    end

    assign result_vector = r_result;

    // Vector bits beyond the dot-product length carry no meaning.
    generate
        if (MATRIX_ROWS > SHARED_DIM) begin : g_spare_vector
            logic w_unused_vector;
            assign w_unused_vector = ^vector[MATRIX_ROWS-1:SHARED_DIM];
        end
    endgenerate

endmodule

// File: tb/tb_mvm_engine.sv
// Randomised scoreboard bench for mvm_engine: a cycle-level reference model
// pushes the expected result_vector each edge, a monitor pops and compares.
module tb_mvm_engine;

    localparam int ROWS = 6;
    localparam int SD   = 3;
    localparam int W    = 8;
    localparam int RW   = SD * W;
    localparam int MW   = ROWS * RW;

    logic            clk    = 1'b0;
    logic            reset  = 1'b1;
    logic            start  = 1'b0;
    logic [MW-1:0]   matrix = '0;
    logic [ROWS-1:0] vector = '0;
    logic [MW-1:0]   result_vector;

    int checks = 0;
    int errors = 0;
    logic [MW-1:0] exp_q[$];

    always #5 clk = ~clk;

    mvm_engine #(.MATRIX_ROWS(ROWS), .SHARED_DIM(SD), .WIDTH(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .matrix        (matrix),
        .vector        (vector),
        .result_vector (result_vector)
    );

    task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: on an accepted start, the full answer is computed from the
    // dot-product definition; k edges later the first k fields are visible.
    int cyc = 0;
    int t_start = 0;
    int next_accept = 0;
    bit active = 1'b0;
    int final_res[ROWS];

    initial begin : model
        logic [MW-1:0] e;
        int k;
        forever begin
            @(posedge clk);
            if (reset) begin
                active      = 1'b0;
                next_accept = cyc + 1;
            end else if (start && cyc >= next_accept) begin
                for (int r = 0; r < ROWS; r++) begin
                    final_res[r] = 0;
                    for (int c = 0; c < SD; c++)
                        final_res[r] += int'(matrix[(r*SD+c)*W +: W]) * int'(vector[c]);
                end
                active      = 1'b1;
                t_start     = cyc;
                // COMPUTE for ROWS edges, one DONE edge, then back in IDLE.
                next_accept = cyc + ROWS + 2;
            end
            e = '0;
            if (active) begin
                k = cyc - t_start;
                if (k > ROWS) k = ROWS;
                for (int r = 0; r < k; r++) e[r*RW +: RW] = RW'(final_res[r]);
            end
            exp_q.push_back(e);
            cyc++;
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0)
                check($sformatf("result_vector edge %0d", cyc - 1), result_vector, exp_q.pop_front());
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input logic [MW-1:0] m, input logic [ROWS-1:0] v);
        matrix = m;
        vector = v;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    function automatic logic [MW-1:0] rand_matrix();
        logic [MW-1:0] m;
        for (int i = 0; i < ROWS*SD; i++) m[i*W +: W] = W'($urandom);
        return m;
    endfunction

    initial begin : stim
        logic [MW-1:0] m;

        #1;
        check("reset_state", result_vector, '0);
        @(negedge clk);
        reset = 1'b0;

        // Zero operands: result stays 0 throughout.
        pulse_start('0, '0);
        step(8);

        // Masked sum on row 0: 10 + 30 with vector 000101.
        m = '0;
        m[0*W +: W] = 8'd10;
        m[1*W +: W] = 8'd20;
        m[2*W +: W] = 8'd30;
        pulse_start(m, 6'b000101);
        step(8);

        // Full-scale, then the same with ignored upper vector bits set.
        pulse_start('1, 6'b000111);
        step(8);
        pulse_start('1, 6'b111111);
        step(8);

        // Row progression with a stray start pulse mid-compute.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < SD; c++) m[(r*SD+c)*W +: W] = W'(r + 1);
        pulse_start(m, 6'b000111);
        step(2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        step(6);

        // Asynchronous reset three edges into an operation.
        pulse_start(rand_matrix(), 6'b000111);
        step(3);
        #1 reset = 1'b1;
        #1 check("async_reset_clear", result_vector, '0);
        @(negedge clk);
        reset = 1'b0;
        pulse_start(rand_matrix(), ROWS'($urandom));
        step(8);

        // Operands changed right after the accepting edge must not matter.
        pulse_start(rand_matrix(), ROWS'($urandom));
        matrix = rand_matrix();
        vector = ROWS'($urandom);
        step(8);

        // Start held high restarts on every return to IDLE.
        matrix = rand_matrix();
        vector = 6'b000111;
        start  = 1'b1;
        step(20);
        start  = 1'b0;
        step(8);

        // Random traffic: sparse start pulses, operands changing every cycle.
        for (int i = 0; i < 300; i++) begin
            start  = ($urandom_range(0, 3) == 0);
            matrix = rand_matrix();
            vector = ROWS'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        step(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
